// File: rtl/bit_serial_adder.sv
// Bit-serial adder: computes {cout,sum} = a + b + cin one bit per clock,
// LSB first, using a single full-adder stage, a carry flop and a small FSM
// (IDLE -> SHIFT for WIDTH edges -> DONE for one cycle -> IDLE).
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_c;

  // Full-adder stage on the current LSBs of the operand shift registers.
  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath update; start is only honoured in IDLE, so
  // operands are frozen for the whole operation and the result holds after it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status and result outputs decode directly from registered state.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = carry_q;
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random self-checking bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int failures;
  int cyc;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) until done is seen 1 ns after a rising edge; n = edges waited.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // One complete addition; leaves the DUT back in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input string tag);
    int n;
    int nb;
    logic [WIDTH:0] exp;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, nb);
    exp = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc};
    // Latency counted inclusively from the accepting edge (edge 0).
    check({tag, " latency"}, 64'(n + 1), 64'(WIDTH + 1));
    check({tag, " busy_cycles"}, 64'(nb), 64'(WIDTH));
    check({tag, " sum"}, 64'(sum), 64'(exp[WIDTH-1:0]));
    check({tag, " cout"}, 64'(cout), 64'(exp[WIDTH]));
    @(posedge clk);
    #1;
    check({tag, " done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, nb, t1, t2, dseen;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    checks = 0;
    failures = 0;
    cyc = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    // Reset state
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst sum",  64'(sum),  64'd0);
    check("rst cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic additions and wrap-around
    run_op(8'h35, 8'h4A, 1'b0, "add35_4a");
    run_op(8'hFF, 8'h01, 1'b0, "addff_01");
    run_op(8'hFF, 8'hFF, 1'b1, "addff_ff_c");
    run_op(8'h00, 8'h00, 1'b1, "add00_c");

    // Result holds while idle inputs change
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; cin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("hold sum",  64'(sum),  64'h01);
    check("hold cout", 64'(cout), 64'd0);
    check("hold busy", 64'(busy), 64'd0);

    // Start held high, operands changed mid-operation
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1;
    wait_done(n, nb);
    t1 = cyc;
    check("held first sum",  64'(sum),  64'h33);
    check("held first cout", 64'(cout), 64'd0);
    n = 0;
    while (!busy && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held restart busy", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    t2 = cyc;
    check("held done spacing", 64'(t2 - t1), 64'd10);
    check("held second sum",  64'(sum),  64'h00);
    check("held second cout", 64'(cout), 64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort sum",  64'(sum),  64'd0);
    check("abort cout", 64'(cout), 64'd0);
    dseen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dseen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) dseen++;
    check("post-reset accept", 64'(busy), 64'd1);
    wait_done(n, nb);
    check("abort no done", 64'(dseen), 64'd0);
    check("post-reset latency", 64'(n + 1), 64'(WIDTH + 1));
    check("post-reset sum",  64'(sum),  64'h30);
    check("post-reset cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(1, 0));
      run_op(ra, rb, rc, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled on clk.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking a completed result.
REQ-010 Port: sum  output  WIDTH  result bits, LSB-first accumulated.
REQ-011 Port: cout  output  1  final carry-out of the addition.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin, one bit per clock, LSB first.
REQ-013 Per-bit stage SHALL be a full adder: s = x^y^c, c_next = xy | xc | yc, where x,y are the current LSBs of the A/B shift registers and c is the carry flop.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE, with IDLE as the reset state.
REQ-015 IDLE: if start=1 at a clock edge, the block SHALL load a, b into shift registers, load cin into the carry flop, clear the bit counter, and go to SHIFT; otherwise it SHALL remain in IDLE.
REQ-016 SHIFT: each edge SHALL right-shift A and B by one, shift s into the MSB of the sum register (right shift), update the carry flop to c_next, and increment the counter.
REQ-017 SHIFT SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly while in SHIFT; done SHALL be 1 exactly while in DONE.
REQ-020 Latency: done SHALL go high WIDTH+1 clock edges after the start-accepting edge, counting the accepting edge as edge 0.
REQ-021 cout SHALL equal the carry flop after the last bit; sum and cout SHALL be valid while done=1 and SHALL hold until the next accepted start.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored: no restart and no operand recapture.
REQ-023 Changes on a, b, cin while not accepting start SHALL NOT affect the result.
REQ-024 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.
REQ-025 Addition wrap-around: a carry out of bit WIDTH-1 SHALL appear only on cout; sum SHALL be the modulo-2^WIDTH result.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry flop, and operand registers.
REQ-027 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start normally.
REQ-028 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-029 WIDTH=8; a=8'h35, b=8'h4A, cin=0, start pulsed for 1 cycle -> busy high for 8 cycles, done one cycle later, sum=8'h7F, cout=0.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; and a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-031 a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0; result holds after done until the next start.
REQ-032 Start held high continuously with operands changed mid-SHIFT -> first result unaffected; next operation begins on the first IDLE edge after DONE, giving back-to-back done pulses 10 cycles apart.
REQ-033 rst_n pulsed low at bit 4 of a=8'hAA, b=8'h55 -> outputs zero immediately with no done pulse; a subsequent start with a=8'h10, b=8'h20 -> sum=8'h30.
REQ-034 Random sweep of at least 1000 operand/cin triples against a reference model -> {cout,sum} matches and done latency is exactly WIDTH+1 edges every time.
